// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//
// Instruction-fetch stage and IF/ID pipeline register of the MIPS core.
// Holds the PC, issues word fetches over a variable-latency req/ack
// instruction-memory port and presents the captured instruction, its PC+4
// and the decoded opcode / 16-bit immediate to the decode stage.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   imem_req     fetch request; imem_addr is stable until imem_ack
//   imem_addr    word address of the outstanding fetch
//   imem_ack     imem_rdata valid this cycle, completes the request
//   imem_rdata   fetched instruction
//   stall        decode cannot accept; IF/ID outputs hold
//   redirect     branch/jump taken: flush IF/ID and refetch at redirect_pc
//   redirect_pc  redirect target (low two bits forced to zero)
//   id_valid     IF/ID holds a valid instruction
//   id_instr     captured instruction
//   id_pc4       address of id_instr + 4
//   id_opcode    id_instr[31:26]
//   id_imm16     id_instr[15:0], feeds the sign extender
//
// FSM:
//   FETCH  request outstanding at pc
//   PEND   a word arrived while decode was stalled; it waits in a
//          one-entry buffer and no new request is issued
//   DRAIN  a redirect happened while a request was still unacknowledged;
//          that request must complete at its original address, and its
//          data is thrown away before fetching from the new pc
// ---------------------------------------------------------------------------
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic [5:0]  id_opcode,
    output logic [15:0] id_imm16
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_PEND  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] drain_addr_q;
    logic [31:0] pend_instr_q;
    logic [31:0] pend_pc4_q;
    logic        id_valid_q;
    logic [31:0] id_instr_q;
    logic [31:0] id_pc4_q;

    logic [31:0] pc4_d;
    logic [31:0] redirect_pc_d;
    logic        ack_eff;

    // Sequential pc increment wraps modulo 2^32.
    assign pc4_d         = pc_q + 32'd4;
    assign redirect_pc_d = redirect_pc & ~32'd3;

    assign imem_req  = !rst && ((state_q == S_FETCH) || (state_q == S_DRAIN));
    // While draining, the abandoned request keeps its address until acked.
    assign imem_addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;

    // An ack with no request outstanding (PEND, reset) is ignored.
    assign ack_eff = imem_ack && imem_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            pend_instr_q <= '0;
            pend_pc4_q   <= '0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= '0;
            id_pc4_q     <= '0;
        end else if (redirect) begin
            // Flush takes effect even under stall; any data arriving this
            // cycle or sitting in the pending buffer belongs to the wrong path.
            pc_q       <= redirect_pc_d;
            id_valid_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (!ack_eff) begin
                        state_q      <= S_DRAIN;
                        drain_addr_q <= pc_q;
                    end
                end
                S_PEND:  state_q <= S_FETCH;
                S_DRAIN: begin
                    if (ack_eff) begin
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (ack_eff) begin
                        pc_q <= pc4_d;
                        if (!stall) begin
                            id_instr_q <= imem_rdata;
                            id_pc4_q   <= pc4_d;
                            id_valid_q <= 1'b1;
                        end else begin
                            pend_instr_q <= imem_rdata;
                            pend_pc4_q   <= pc4_d;
                            state_q      <= S_PEND;
                        end
                    end else if (!stall) begin
                        id_valid_q <= 1'b0;
                    end
                end
                S_PEND: begin
                    if (!stall) begin
                        id_instr_q <= pend_instr_q;
                        id_pc4_q   <= pend_pc4_q;
                        id_valid_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (ack_eff) begin
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc4    = id_pc4_q;
    assign id_opcode = id_instr_q[31:26];
    assign id_imm16  = id_instr_q[15:0];

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the MIPS core.
- Keeps the PC and fetches 32-bit words over a variable-latency req/ack instruction-memory port.
- Presents the captured instruction, PC+4 and decoded fields to decode. id_imm16 feeds the sign-extension unit directly.
- Supports downstream stall, a one-entry pending buffer, and branch/jump redirect with in-flight response discard.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request; address must stay stable until imem_ack
imem_addr  out  32  word address of the current fetch
imem_ack  in  1  imem_rdata valid this cycle; completes the request
imem_rdata  in  32  fetched instruction
stall  in  1  decode cannot accept; IF/ID outputs hold
redirect  in  1  branch/jump taken; flush and refetch
redirect_pc  in  32  redirect target, low 2 bits ignored (forced 0)
id_valid  out  1  IF/ID holds a valid instruction
id_instr  out  32  captured instruction
id_pc4  out  32  address of id_instr + 4
id_opcode  out  6  id_instr[31:26]
id_imm16  out  16  id_instr[15:0], to the sign extender

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high (rst). All state is updated on the rising edge of clk.
- Reset values: pc=RESET_PC, state=FETCH, id_valid=0, id_instr=0, id_pc4=0, pending buffer=0. imem_req=0 while rst is high.
- FSM states: FETCH, PEND, DRAIN.
- imem_req = !rst && (state==FETCH || state==DRAIN).
- imem_addr = pc in FETCH. In DRAIN it is the held address of the outstanding request.
- Priority order, highest first: rst, redirect, ack/stall handling.

FETCH:
- ack && !stall: id_instr<=rdata, id_pc4<=pc+4, id_valid<=1, pc<=pc+4. Stay in FETCH, so back-to-back fetches run at one instruction per cycle with a 1-cycle memory.
- ack && stall: pending<=rdata, pending_pc4<=pc+4, pc<=pc+4. IF/ID outputs hold. Go to PEND.
- !ack && !stall: id_valid<=0 (bubble).
- !ack && stall: IF/ID outputs hold.

PEND:
- imem_req=0.
- !stall: IF/ID<=pending, id_valid<=1. Go to FETCH.
- stall: hold.

DRAIN:
- imem_req stays 1 with the old address.
- On ack: rdata is discarded. Go to FETCH, fetching from pc (the redirect target).

Redirect (any state):
- id_valid<=0 next cycle, even if stall=1.
- pc<=redirect_pc & ~3.
- FETCH with ack in the same cycle: rdata discarded, next state FETCH.
- FETCH without ack: go to DRAIN, because the outstanding request must complete.
- PEND: pending buffer discarded, go to FETCH.
- DRAIN: target updated to the new redirect_pc, stay in DRAIN until ack.
- ack in the same cycle as a DRAIN redirect: discard rdata, go to FETCH.

Other rules:
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- id_opcode and id_imm16 are pure slices of id_instr, with no extra latency.
- imem_ack received while imem_req=0 is ignored.
- rst asserted mid-operation (any state, outstanding request) returns everything to reset values on the next edge. A late ack after reset is treated as the response to the new RESET_PC request, so the memory model must drop its request on rst.

Test Plan:
1. Reset then 1-cycle memory returning 32'h2008_A43D at 0 and 32'h2009_7A0B at 4 -> id_instr=2008A43D, id_pc4=4, id_imm16=A43D the cycle after the first ack; next cycle id_imm16=7A0B, id_pc4=8.
2. 3-cycle memory latency -> id_valid is 0 for 2 cycles between instructions; imem_addr is held constant until ack.
3. stall=1 for 3 cycles with ack arriving during the stall -> state PEND, imem_req=0, IF/ID unchanged. On stall release, pending instruction appears with the correct id_pc4 and no instruction is lost or duplicated.
4. redirect to 32'h0000_0040 while a request is outstanding and unacked -> DRAIN. The old ack data never reaches IF/ID. The next imem_addr is 40 and the first valid id_pc4 is 44.
5. redirect coincident with ack, and redirect with stall=1 in PEND -> id_valid=0 the next cycle; the fetch restarts at the target.
6. rst asserted in DRAIN and in PEND -> next cycle pc=RESET_PC, id_valid=0, id_instr=0, imem_req=0 while rst is high; fetch resumes from RESET_PC after rst drops.
